// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns one synchronous active-high reset (plus a soft-reset request) into
//   NCHAN registered "in reset" levels. All levels are held for HOLD_CYCLES
//   after the last trigger, then released one channel at a time, lowest index
//   first, STAGGER_CYCLES apart (0 = all together).
//
// Ports
//   CLK      : clock, all state changes on the rising edge
//   RST      : synchronous active-high reset
//   SOFT_RST : soft-reset request, level-sensitive, same effect as RST
//   VAL      : bit i = 1 while channel i is held in reset (thermometer-shaped)
//   READY    : 1 once every channel is released
//   STAGE    : number of channels released so far, 0..NCHAN
module reset_sequencer #(
  parameter  int unsigned NCHAN          = 4,
  parameter  int unsigned HOLD_CYCLES    = 16,
  parameter  int unsigned STAGGER_CYCLES = 8,
  localparam int unsigned MAXC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES,
  localparam int unsigned CW   = $clog2(MAXC + 1),
  localparam int unsigned SW   = $clog2(NCHAN + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SOFT_RST,
  output logic [NCHAN-1:0] VAL,
  output logic             READY,
  output logic [SW-1:0]    STAGE
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_STAGGER,
    S_DONE
  } state_e;

  // Terminal counts: the release happens on the edge where the counter
  // would step onto HOLD_CYCLES / STAGGER_CYCLES, i.e. while it holds N-1.
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STG_LAST  = (STAGGER_CYCLES == 0) ? '0 : CW'(STAGGER_CYCLES - 1);
  localparam logic [SW-1:0] LAST_CH   = SW'(NCHAN - 1);
  localparam logic [SW-1:0] ALL_CH    = SW'(NCHAN);
  // A single channel or zero stagger means the first release is the last.
  localparam bit            ONE_SHOT  = (NCHAN == 1) || (STAGGER_CYCLES == 0);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [NCHAN-1:0] val_q, val_d;
  logic             ready_q, ready_d;
  logic             trig;

  assign trig = RST | SOFT_RST;

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      val_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      val_q   <= val_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (trig) begin
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = ONE_SHOT ? S_DONE : S_STAGGER;
        end
        S_STAGGER: begin
          if ((cnt_q == STG_LAST) && (stage_q == LAST_CH)) state_d = S_DONE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_HOLD;
      endcase
    end
  end

  // Counter / stage / output values for the next edge
  always_comb begin
    cnt_d   = cnt_q;
    stage_d = stage_q;
    if (trig) begin
      cnt_d   = '0;
      stage_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            stage_d = (STAGGER_CYCLES == 0) ? ALL_CH : SW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STAGGER: begin
          if (cnt_q == STG_LAST) begin
            cnt_d   = '0;
            stage_d = stage_q + SW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end
    // VAL is derived from the stage so it is thermometer-shaped by construction.
    val_d   = {NCHAN{1'b1}} << stage_d;
    ready_d = (state_d == S_DONE);
  end

  assign VAL   = val_q;
  assign READY = ready_q;
  assign STAGE = stage_q;

endmodule
